// File: rtl/bit_serializer.sv
// MSB-first parallel-to-serial converter with a programmable idle gap after each word.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after the data bits.
module bit_serializer #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned GAP   = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_valid,
    output logic             load_ready,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             busy,
    output logic [7:0]       words_sent
);

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StShift  = 2'd1,
        StGap    = 2'd2
`ifdef BIT_SERIALIZER_PARITY_EN
        ,
        StParity = 2'd3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [5:0]       cnt_q, cnt_d;
    logic             out_q, out_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic [7:0]       words_q, words_d;
    logic             word_done;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic             par_q, par_d;
`endif

    always_comb begin
        state_d   = state_q;
        shreg_d   = shreg_q;
        cnt_d     = cnt_q;
        out_d     = 1'b0;
        valid_d   = 1'b0;
        busy_d    = busy_q;
        words_d   = words_q;
        word_done = 1'b0;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d     = par_q;
`endif
        case (state_q)
            StIdle: begin
                busy_d = 1'b0;
                if (load_valid) begin
                    // MSB goes out immediately; the remaining bits wait in the shifter
                    state_d = StShift;
                    shreg_d = data_in << 1;
                    out_d   = data_in[WIDTH-1];
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                    cnt_d   = 6'd1;
`ifdef BIT_SERIALIZER_PARITY_EN
                    par_d   = ^data_in;
`endif
                end
            end
            StShift: begin
                if (cnt_q == 6'(WIDTH)) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = StParity;
                    out_d   = par_q;
                    valid_d = 1'b1;
`else
                    word_done = 1'b1;
`endif
                end else begin
                    out_d   = shreg_q[WIDTH-1];
                    valid_d = 1'b1;
                    shreg_d = shreg_q << 1;
                    cnt_d   = cnt_q + 6'd1;
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            StParity: begin
                word_done = 1'b1;
            end
`endif
            StGap: begin
                if (cnt_q == 6'(GAP)) begin
                    state_d = StIdle;
                    busy_d  = 1'b0;
                    cnt_d   = 6'd0;
                end else begin
                    cnt_d = cnt_q + 6'd1;
                end
            end
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = 6'd0;
                busy_d  = 1'b0;
                words_d = 8'd0;
`ifdef BIT_SERIALIZER_PARITY_EN
                par_d   = 1'b0;
`endif
            end
        endcase

        // Final bit has just been shown: count the word and start the gap (if any)
        if (word_done) begin
            words_d = words_q + 8'd1;
            if (GAP == 0) begin
                state_d = StIdle;
                busy_d  = 1'b0;
                cnt_d   = 6'd0;
            end else begin
                state_d = StGap;
                busy_d  = 1'b1;
                cnt_d   = 6'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= 6'd0;
            out_q   <= 1'b0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            words_q <= 8'd0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            words_q <= words_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign load_ready   = (state_q == StIdle);
    assign serial_out   = out_q;
    assign serial_valid = valid_q;
    assign busy         = busy_q;
    assign words_sent   = words_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: scoreboard of expected serial bits, one task per scenario.
module tb_bit_serializer;

    localparam int W = 8;
    localparam int G = 2;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int NB      = W + PAR;
    localparam int PERIOD  = W + G + 1 + PAR;
    localparam int PERIOD0 = W + 1 + PAR;

    logic         clk;
    logic         reset;
    logic [W-1:0] data_in;
    logic         load_valid;
    logic         load_ready;
    logic         serial_out;
    logic         serial_valid;
    logic         busy;
    logic [7:0]   words_sent;

    logic [W-1:0] data0;
    logic         valid0;
    logic         ready0;
    logic         sout0;
    logic         svalid0;
    logic         busy0;
    logic [7:0]   words0;

    int checks   = 0;
    int failures = 0;
    int exp_words = 0;
    logic exp_q[$];
    bit   last_q[$];

    bit_serializer #(.WIDTH(W), .GAP(G)) dut (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data_in),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .serial_out   (serial_out),
        .serial_valid (serial_valid),
        .busy         (busy),
        .words_sent   (words_sent)
    );

    bit_serializer #(.WIDTH(W), .GAP(0)) dut0 (
        .clk          (clk),
        .reset        (reset),
        .data_in      (data0),
        .load_valid   (valid0),
        .load_ready   (ready0),
        .serial_out   (sout0),
        .serial_valid (svalid0),
        .busy         (busy0),
        .words_sent   (words0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        for (int i = W - 1; i >= 0; i--) begin
            exp_q.push_back(w[i]);
            last_q.push_back((i == 0) && (PAR == 0));
        end
`ifdef BIT_SERIALIZER_PARITY_EN
        exp_q.push_back(^w);
        last_q.push_back(1'b1);
`endif
    endtask

    task automatic test_reset();
        reset = 1'b0; load_valid = 1'b0; data_in = '0; valid0 = 1'b0; data0 = '0;
        repeat (3) tick();
        checks++;
        if ({serial_out, serial_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_outputs: got %b want 000", {serial_out, serial_valid, busy});
        end
        checks++;
        if (words_sent !== 8'd0) begin
            failures++; $display("FAIL reset_words: got %0d want 0", words_sent);
        end
        checks++;
        if (words0 !== 8'd0) begin
            failures++; $display("FAIL reset_words_gap0: got %0d want 0", words0);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++; $display("FAIL reset_ready: got %b want 1", load_ready);
        end
        checks++;
        if ({serial_out, serial_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL reset_idle: got %b want 000", {serial_out, serial_valid, busy});
        end
    endtask

    task automatic test_abort();
        bit resumed;
        data_in = 8'hFF; load_valid = 1'b1;
        tick();                      // cycle k+1
        load_valid = 1'b0;
        repeat (3) tick();           // cycle k+4
        checks++;
        if ({busy, serial_valid, serial_out} !== 3'b111) begin
            failures++; $display("FAIL abort_inflight: got %b want 111", {busy, serial_valid, serial_out});
        end
        reset = 1'b0;
        tick();                      // cycle k+5
        checks++;
        if ({serial_out, serial_valid, busy} !== 3'b000) begin
            failures++; $display("FAIL abort_outputs: got %b want 000", {serial_out, serial_valid, busy});
        end
        checks++;
        if (words_sent !== 8'd0) begin
            failures++; $display("FAIL abort_words: got %0d want 0", words_sent);
        end
        reset = 1'b1;
        tick();
        checks++;
        if (load_ready !== 1'b1) begin
            failures++; $display("FAIL abort_ready: got %b want 1", load_ready);
        end
        resumed = 1'b0;
        repeat (12) begin
            if (serial_valid !== 1'b0 || busy !== 1'b0) resumed = 1'b1;
            tick();
        end
        checks++;
        if (resumed) begin
            failures++; $display("FAIL abort_no_resume: got activity want none");
        end
        checks++;
        if (words_sent !== 8'd0) begin
            failures++; $display("FAIL abort_words_after: got %0d want 0", words_sent);
        end
    endtask

    task automatic test_a5();
        logic e;
        data_in = 8'hA5; load_valid = 1'b1;
        push_word(8'hA5);
        tick();                      // cycle k+1
        load_valid = 1'b0;
        data_in = W'($urandom);
        for (int i = 0; i < NB; i++) begin
            e = exp_q.pop_front();
            void'(last_q.pop_front());
            checks++;
            if (serial_valid !== 1'b1 || serial_out !== e) begin
                failures++;
                $display("FAIL a5_bit%0d: got valid=%b out=%b want valid=1 out=%b", i, serial_valid, serial_out, e);
            end
            if (i < NB - 1) tick();
        end
        tick();                      // first cycle after the final bit
        exp_words++;
        checks++;
        if (words_sent !== 8'(exp_words)) begin
            failures++; $display("FAIL a5_words: got %0d want %0d", words_sent, exp_words);
        end
        for (int g = 0; g < G; g++) begin
            checks++;
            if ({serial_out, serial_valid, busy} !== 3'b001) begin
                failures++; $display("FAIL a5_gap%0d: got %b want 001", g, {serial_out, serial_valid, busy});
            end
            tick();
        end
        checks++;
        if ({load_ready, busy} !== 2'b10) begin
            failures++; $display("FAIL a5_idle: got %b want 10", {load_ready, busy});
        end
    endtask

    task automatic test_patterns();
        logic [W-1:0] words [4];
        logic e;
        words[0] = 8'h07; words[1] = 8'h03; words[2] = 8'h80; words[3] = W'($urandom);
        for (int n = 0; n < 4; n++) begin
            data_in = words[n]; load_valid = 1'b1;
            push_word(words[n]);
            tick();
            load_valid = 1'b0;
            for (int i = 0; i < NB; i++) begin
                e = exp_q.pop_front();
                void'(last_q.pop_front());
                checks++;
                if (serial_valid !== 1'b1 || serial_out !== e) begin
                    failures++;
                    $display("FAIL pat%0h_bit%0d: got valid=%b out=%b want valid=1 out=%b",
                             words[n], i, serial_valid, serial_out, e);
                end
                if (i < NB - 1) tick();
            end
            repeat (G + 1) tick();
            exp_words++;
            checks++;
            if (load_ready !== 1'b1 || words_sent !== 8'(exp_words)) begin
                failures++;
                $display("FAIL pat%0h_end: got ready=%b words=%0d want ready=1 words=%0d",
                         words[n], load_ready, words_sent, exp_words);
            end
        end
    endtask

    task automatic test_hold();
        bit accepted;
        int t;
        logic e;
        data_in = 8'h3C; load_valid = 1'b1;
        push_word(8'h3C);
        accepted = 1'b0;
        t = 0;
        do begin
            tick();
            t++;
            if (serial_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL hold_extra_bit: got valid=1 want no bit pending");
                end else begin
                    e = exp_q.pop_front();
                    void'(last_q.pop_front());
                    if (serial_out !== e) begin
                        failures++; $display("FAIL hold_bit_t%0d: got %b want %b", t, serial_out, e);
                    end
                end
            end
            if (!accepted) begin
                if (load_ready === 1'b1) begin
                    checks++;
                    if (t != PERIOD) begin
                        failures++; $display("FAIL hold_accept_edge: got k+%0d want k+%0d", t, PERIOD);
                    end
                    data_in = 8'h5A;
                    push_word(8'h5A);
                    accepted = 1'b1;
                end else begin
                    data_in = W'($urandom);
                end
            end else begin
                load_valid = 1'b0;
                data_in = W'($urandom);
            end
        end while (!(accepted && exp_q.size() == 0) && t < 4 * PERIOD);
        checks++;
        if (exp_q.size() != 0 || !accepted) begin
            failures++; $display("FAIL hold_timeout: got %0d bits pending want 0", exp_q.size());
        end
        exp_q.delete(); last_q.delete();
        load_valid = 1'b0;
        for (int i = 0; i < G + 4 && load_ready !== 1'b1; i++) tick();
        exp_words += 2;
        checks++;
        if (words_sent !== 8'(exp_words)) begin
            failures++; $display("FAIL hold_words: got %0d want %0d", words_sent, exp_words);
        end
    endtask

    task automatic test_wrap();
        int accepted, done, t, last_acc;
        bit pending;
        logic [W-1:0] w;
        logic e;
        reset = 1'b0; load_valid = 1'b0;
        tick();
        reset = 1'b1;
        tick();
        accepted = 0; done = 0; t = 0; last_acc = 0; pending = 1'b0;
        while ((done < 256 || pending) && t < 256 * PERIOD + 50) begin
            if (pending) begin
                checks++;
                if (words_sent !== 8'(done)) begin
                    failures++; $display("FAIL wrap_count_w%0d: got %0d want %0d", done, words_sent, done % 256);
                end
                pending = 1'b0;
            end
            if (serial_valid === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++; $display("FAIL wrap_extra_bit: got valid=1 want no bit pending");
                end else begin
                    e = exp_q.pop_front();
                    if (serial_out !== e) begin
                        failures++; $display("FAIL wrap_bit_t%0d: got %b want %b", t, serial_out, e);
                    end
                    if (last_q.pop_front()) begin
                        done++;
                        pending = 1'b1;
                    end
                end
            end
            if (load_ready === 1'b1 && accepted < 256) begin
                if (accepted > 0) begin
                    checks++;
                    if (t - last_acc != PERIOD) begin
                        failures++; $display("FAIL wrap_period: got %0d want %0d", t - last_acc, PERIOD);
                    end
                end
                w = W'($urandom);
                data_in = w; load_valid = 1'b1;
                push_word(w);
                accepted++;
                last_acc = t;
            end else begin
                load_valid = (accepted < 256);
                data_in = W'($urandom);
            end
            tick();
            t++;
        end
        checks++;
        if (done != 256) begin
            failures++; $display("FAIL wrap_timeout: got %0d words want 256", done);
        end
        checks++;
        if (words_sent !== 8'd0) begin
            failures++; $display("FAIL wrap_final: got %0d want 0", words_sent);
        end
        load_valid = 1'b0;
        exp_q.delete(); last_q.delete();
    endtask

    task automatic test_gap0();
        logic [1:0] exp0_q[$];
        logic [1:0] e;
        for (int i = W - 1; i >= 0; i--) exp0_q.push_back({1'b1, 1'b1 & (i >= 5)});
`ifdef BIT_SERIALIZER_PARITY_EN
        exp0_q.push_back(2'b11);
`endif
        exp0_q.push_back(2'b00);
        for (int i = 0; i < W; i++) exp0_q.push_back(2'b10);
`ifdef BIT_SERIALIZER_PARITY_EN
        exp0_q.push_back(2'b10);
`endif
        data0 = 8'hE0; valid0 = 1'b1;
        tick();
        data0 = 8'h00;
        for (int t = 1; t <= 2 * PERIOD0 - 1; t++) begin
            e = exp0_q.pop_front();
            checks++;
            if ({svalid0, sout0} !== e) begin
                failures++; $display("FAIL gap0_t%0d: got valid,out=%b want %b", t, {svalid0, sout0}, e);
            end
            if (t == PERIOD0) begin
                checks++;
                if (words0 !== 8'd1 || ready0 !== 1'b1) begin
                    failures++; $display("FAIL gap0_idle: got words=%0d ready=%b want 1 1", words0, ready0);
                end
            end
            if (t > PERIOD0) valid0 = 1'b0;
            tick();
        end
        checks++;
        if (words0 !== 8'd2 || ready0 !== 1'b1 || svalid0 !== 1'b0) begin
            failures++;
            $display("FAIL gap0_end: got words=%0d ready=%b valid=%b want 2 1 0", words0, ready0, svalid0);
        end
    endtask

    initial begin
        test_reset();
        test_abort();
        test_a5();
        test_patterns();
        test_hold();
        test_wrap();
        test_gap0();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
